// File: rtl/mem_access_unit.sv
// Load/store initiator between the multicycle CPU datapath and the byte-lane data RAM.
// Define MAU_ALIGN_CHECK_EN to report misaligned half/word accesses as AdEL/AdES errors.
module mem_access_unit #(
    parameter logic [31:0] ADDR_BASE = 32'h1001_0000,
    parameter logic [31:0] ADDR_MASK = 32'h0000_1FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic        resp_err,
    output logic        resp_err_store,
    output logic [31:0] resp_rdata,
    output logic [31:0] resp_badvaddr,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_mask,
    output logic        mem_signed_ext,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        xfer;
    logic [31:0] offset;
    logic [31:0] issue_addr;

    assign xfer   = req_valid & req_ready;
    // Modulo-2^32 rebase, so addresses below the window wrap into it.
    assign offset = (req_addr - ADDR_BASE) & ADDR_MASK;

`ifdef MAU_ALIGN_CHECK_EN
    logic        misaligned;
    logic        err_q;
    logic        err_store_q;
    logic [31:0] badvaddr_q;

    always_comb begin
        misaligned = 1'b0;
        if (req_size[1])
            misaligned = |req_addr[1:0];
        else if (req_size[0])
            misaligned = req_addr[0];
    end

    assign issue_addr = offset;
`else
    always_comb begin
        issue_addr = offset;
        if (req_size[1])
            issue_addr = {offset[31:2], 2'b00};
        else if (req_size[0])
            issue_addr = {offset[31:1], 1'b0};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
`ifdef MAU_ALIGN_CHECK_EN
            err_q       <= 1'b0;
            err_store_q <= 1'b0;
            badvaddr_q  <= 32'h0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= issue_addr;
                        wdata_q  <= req_wdata;
`ifdef MAU_ALIGN_CHECK_EN
                        if (misaligned) begin
                            err_q       <= 1'b1;
                            err_store_q <= req_we;
                            badvaddr_q  <= req_addr;
                            state       <= DONE;
                        end else begin
                            err_q       <= 1'b0;
                            err_store_q <= 1'b0;
                            state       <= ACCESS;
                        end
`else
                        state <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        resp_rdata <= mem_rdata;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign resp_done = (state == DONE);
    // Reset is sampled only at the edge, so gate the strobe to stop the write now.
    assign mem_we    = (state == ACCESS) & we_q & ~reset;

    assign mem_addr       = addr_q;
    assign mem_mask       = size_q;
    assign mem_signed_ext = signed_q;
    assign mem_wdata      = wdata_q;

`ifdef MAU_ALIGN_CHECK_EN
    assign resp_err       = (state == DONE) & err_q;
    assign resp_err_store = (state == DONE) & err_q & err_store_q;
    assign resp_badvaddr  = badvaddr_q;
`else
    assign resp_err       = 1'b0;
    assign resp_err_store = 1'b0;
    assign resp_badvaddr  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-lane RAM model attached.
// Covers latency, lane extension, wrap/mask, alignment, reset abort and streaming.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic        resp_err;
    logic        resp_err_store;
    logic [31:0] resp_rdata;
    logic [31:0] resp_badvaddr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_mask;
    logic        mem_signed_ext;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0;
    int xfer_cnt = 0;

    logic [7:0]  ram [0:8191];
    logic [12:0] ra;
    logic [7:0]  rb;
    logic [15:0] rh;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_done      (resp_done),
        .resp_err       (resp_err),
        .resp_err_store (resp_err_store),
        .resp_rdata     (resp_rdata),
        .resp_badvaddr  (resp_badvaddr),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_mask       (mem_mask),
        .mem_signed_ext (mem_signed_ext),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    assign ra = mem_addr[12:0];

    // Byte-lane RAM: little-endian, extension done on the read side.
    always_comb begin
        rb = ram[ra];
        rh = {ram[{ra[12:1], 1'b1}], ram[{ra[12:1], 1'b0}]};
        mem_rdata = 32'h0;
        case (mem_mask)
            2'b00: mem_rdata = mem_signed_ext ? {{24{rb[7]}}, rb} : {24'h0, rb};
            2'b01: mem_rdata = mem_signed_ext ? {{16{rh[15]}}, rh} : {16'h0, rh};
            default: mem_rdata = {ram[{ra[12:2], 2'd3}], ram[{ra[12:2], 2'd2}],
                                  ram[{ra[12:2], 2'd1}], ram[{ra[12:2], 2'd0}]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_mask)
                2'b00: ram[ra] <= mem_wdata[7:0];
                2'b01: begin
                    ram[{ra[12:1], 1'b0}] <= mem_wdata[7:0];
                    ram[{ra[12:1], 1'b1}] <= mem_wdata[15:8];
                end
                default: begin
                    ram[{ra[12:2], 2'd0}] <= mem_wdata[7:0];
                    ram[{ra[12:2], 2'd1}] <= mem_wdata[15:8];
                    ram[{ra[12:2], 2'd2}] <= mem_wdata[23:16];
                    ram[{ra[12:2], 2'd3}] <= mem_wdata[31:24];
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mem_we)
            we_cnt <= we_cnt + 1;
    end

    always @(posedge clk) begin
        if (!reset && req_valid && req_ready)
            xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Present a request in IDLE; returns 1ns after the transfer edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_ok(input string tag, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_rdata);
        int w0;
        issue(we, sz, sg, a, wd);
        w0 = we_cnt;
        check({tag, ".acc_ready"}, {31'h0, req_ready}, 32'h0);
        check({tag, ".acc_we"}, {31'h0, mem_we}, {31'h0, we});
        check({tag, ".acc_addr"}, mem_addr, exp_maddr);
        check({tag, ".acc_wdata"}, mem_wdata, wd);
        check({tag, ".acc_done"}, {31'h0, resp_done}, 32'h0);
        @(posedge clk);
        #1;
        check({tag, ".done"}, {31'h0, resp_done}, 32'h1);
        check({tag, ".err"}, {31'h0, resp_err}, 32'h0);
        check({tag, ".done_we"}, {31'h0, mem_we}, 32'h0);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".we_pulses"}, we_cnt - w0, {31'h0, we});
        @(posedge clk);
        #1;
        check({tag, ".idle_done"}, {31'h0, resp_done}, 32'h0);
        check({tag, ".idle_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

`ifdef MAU_ALIGN_CHECK_EN
    task automatic run_err(input string tag, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] exp_rdata);
        int w0;
        w0 = we_cnt;
        issue(we, sz, 1'b0, a, 32'hCAFE_F00D);
        check({tag, ".done"}, {31'h0, resp_done}, 32'h1);
        check({tag, ".err"}, {31'h0, resp_err}, 32'h1);
        check({tag, ".err_store"}, {31'h0, resp_err_store}, {31'h0, we});
        check({tag, ".badvaddr"}, resp_badvaddr, a);
        check({tag, ".we"}, {31'h0, mem_we}, 32'h0);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({tag, ".idle_done"}, {31'h0, resp_done}, 32'h0);
        check({tag, ".idle_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, ".we_pulses"}, we_cnt - w0, 32'h0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addrs [0:2];
        logic [31:0] vals [0:2];
        int w0;
        int x0;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", {31'h0, req_ready}, 32'h1);
        check("rst.done", {31'h0, resp_done}, 32'h0);
        check("rst.err", {31'h0, resp_err}, 32'h0);
        check("rst.err_store", {31'h0, resp_err_store}, 32'h0);
        check("rst.we", {31'h0, mem_we}, 32'h0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.badvaddr", resp_badvaddr, 32'h0);
        check("rst.maddr", mem_addr, 32'h0);
        check("rst.wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        run_ok("sw4", 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h4, 32'h0);
        run_ok("lw4", 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'h4, 32'hDEAD_BEEF);

        run_ok("sw8", 1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'h0, 32'h8, 32'hDEAD_BEEF);
        run_ok("sb9", 1'b1, 2'b00, 1'b0, 32'h1001_0009, 32'h0000_0080, 32'h9, 32'hDEAD_BEEF);
        run_ok("lb9", 1'b0, 2'b00, 1'b1, 32'h1001_0009, 32'h0, 32'h9, 32'hFFFF_FF80);
        run_ok("lbu9", 1'b0, 2'b00, 1'b0, 32'h1001_0009, 32'h0, 32'h9, 32'h0000_0080);
        run_ok("lw8", 1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, 32'h8, 32'h0000_8000);

        run_ok("sw10", 1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 32'h10, 32'h0000_8000);
        run_ok("sh12", 1'b1, 2'b01, 1'b0, 32'h1001_0012, 32'h1234_8001, 32'h12, 32'h0000_8000);
        run_ok("lh12", 1'b0, 2'b01, 1'b1, 32'h1001_0012, 32'h0, 32'h12, 32'hFFFF_8001);
        run_ok("lhu12", 1'b0, 2'b01, 1'b0, 32'h1001_0012, 32'h0, 32'h12, 32'h0000_8001);

        run_ok("sw_top", 1'b1, 2'b10, 1'b0, 32'h1001_1FFC, 32'hAABB_CCDD, 32'h1FFC, 32'h0000_8001);
        run_ok("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0, 32'h1FFC, 32'hAABB_CCDD);
        run_ok("lw_mask", 1'b0, 2'b10, 1'b0, 32'h1001_2004, 32'h0, 32'h4, 32'hDEAD_BEEF);

`ifdef MAU_ALIGN_CHECK_EN
        run_err("lw6_adel", 1'b0, 2'b10, 32'h1001_0006, 32'hDEAD_BEEF);
        run_err("sh1_ades", 1'b1, 2'b01, 32'h1001_0001, 32'hDEAD_BEEF);
`else
        run_ok("lw6_clr", 1'b0, 2'b10, 1'b0, 32'h1001_0006, 32'h0, 32'h4, 32'hDEAD_BEEF);
        run_ok("sh13_clr", 1'b1, 2'b01, 1'b0, 32'h1001_0013, 32'h0000_5566, 32'h12, 32'hDEAD_BEEF);
        run_ok("lhu12b", 1'b0, 2'b01, 1'b0, 32'h1001_0012, 32'h0, 32'h12, 32'h0000_5566);
`endif

        run_ok("sw0", 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h1122_3344, 32'h0, resp_rdata);
        w0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        check("abort.we", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort.done", {31'h0, resp_done}, 32'h0);
        check("abort.ready", {31'h0, req_ready}, 32'h1);
        check("abort.rdata", resp_rdata, 32'h0);
        @(posedge clk);
        #1;
        check("abort.done2", {31'h0, resp_done}, 32'h0);
        check("abort.we_pulses", we_cnt - w0, 32'h0);
        run_ok("lw0", 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 32'h1122_3344);

        addrs[0] = 32'h1001_0100;
        addrs[1] = 32'h1001_0104;
        addrs[2] = 32'h1001_0108;
        vals[0]  = 32'hA1A1_0001;
        vals[1]  = 32'hB2B2_0002;
        vals[2]  = 32'hC3C3_0003;
        for (int k = 0; k < 3; k++)
            run_ok("sw_strm", 1'b1, 2'b10, 1'b0, addrs[k], vals[k], addrs[k] - 32'h1001_0000, 32'h1122_3344);

        x0 = xfer_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = addrs[0];
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("strm.ready", {31'h0, req_ready}, (i % 3 == 0) ? 32'h1 : 32'h0);
            check("strm.done", {31'h0, resp_done}, (i % 3 == 2) ? 32'h1 : 32'h0);
            if (i % 3 == 0)
                req_addr = addrs[i / 3];
            if (i % 3 == 2)
                check("strm.rdata", resp_rdata, vals[i / 3]);
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("strm.xfers", xfer_cnt - x0, 32'h3);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
